sd_card_cmd_responder: RTL

- Card-side endpoint of the SD CMD line, synthesizable, for loopback with sdc_controller.
- Deserializes 48-bit host commands and checks the CRC7.
- Tracks a minimal card state (idle/stby/tran) and serializes R1/R3/R6 responses after a programmable NCR gap.
- Pulses a read request toward a data-line responder for CMD17 and ACMD51.

---
 rtl/sd_card_cmd_responder_if.sv | 26 ++
 rtl/sd_card_cmd_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sd_card_cmd_responder_if.sv
// CMD-line bundle between an SD host (master) and the card-side command responder (slave).
// Also carries the accepted-command report and the read request toward the data-line side.
interface sd_card_cmd_responder_if;
    logic        cmd_in;
    logic        cmd_out;
    logic        cmd_oe;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        rd_start;
    logic [31:0] rd_addr;
    logic        rd_scr;
    logic        crc_err;

    modport master (
        output cmd_in,
        input  cmd_out, cmd_oe, cmd_valid, cmd_index, cmd_arg, rd_start, rd_addr, rd_scr,
        input  crc_err
    );

    modport slave (
        input  cmd_in,
        output cmd_out, cmd_oe, cmd_valid, cmd_index, cmd_arg, rd_start, rd_addr, rd_scr,
        output crc_err
    );
endinterface

// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD endpoint: receives 48-bit commands, checks CRC7, tracks a minimal card
// state and returns R1/R3/R6 responses after an NCR gap; requests block/SCR reads.
module sd_card_cmd_responder #(
    parameter logic [15:0] RCA = 16'h0013,
    parameter int unsigned NCR = 2,
    parameter logic [31:0] OCR = 32'h80FF8000
) (
    input logic                    clk,
    input logic                    rst,
    sd_card_cmd_responder_if.slave sd_io
);

    typedef enum logic [2:0] {StRxIdle, StRx, StCheck, StWait, StTx} state_e;
    typedef enum logic [3:0] {
        CardIdle  = 4'd0,
        CardReady = 4'd1,
        CardStby  = 4'd3,
        CardTran  = 4'd4
    } card_e;
    typedef enum logic [1:0] {RespNone, RespR1, RespR3, RespR6} resp_e;

    // The CHECK cycle is the first idle cycle of the gap, so WAIT lasts NCR-1 cycles.
    localparam logic [5:0] WaitLast = 6'(NCR - 2);

    function automatic logic [6:0] crc7_step(logic [6:0] c, logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:3], c[2] ^ fb, c[1:0], fb};
    endfunction

    function automatic logic [6:0] crc7_of(logic [39:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
        return c;
    endfunction

    state_e      state_q, state_d;
    card_e       card_state_q, card_state_d;
    logic        app_q, app_d;
    logic        err_crc_q, err_crc_d;
    logic        err_ill_q, err_ill_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [6:0]  crc_q, crc_d;
    logic [45:0] rx_sr_q, rx_sr_d;
    logic [47:0] tx_sr_q, tx_sr_d;
    logic        rd_pend_q, rd_pend_d;
    logic        valid_q, valid_d;
    logic [5:0]  index_q, index_d;
    logic [31:0] arg_q, arg_d;
    logic [31:0] rd_addr_q, rd_addr_d;
    logic        rd_scr_q, rd_scr_d;
    logic        crc_err_q, crc_err_d;

    logic [5:0]  rx_idx;
    logic [31:0] rx_arg;
    logic [6:0]  rx_crc;
    logic        rx_end;
    resp_e       resp;
    logic [31:0] status;
    logic [39:0] body;

    assign {rx_idx, rx_arg, rx_crc, rx_end} = rx_sr_q;

    always_comb begin
        state_d      = state_q;
        card_state_d = card_state_q;
        app_d        = app_q;
        err_crc_d    = err_crc_q;
        err_ill_d    = err_ill_q;
        cnt_d        = cnt_q;
        crc_d        = crc_q;
        rx_sr_d      = rx_sr_q;
        tx_sr_d      = tx_sr_q;
        rd_pend_d    = rd_pend_q;
        valid_d      = 1'b0;
        index_d      = index_q;
        arg_d        = arg_q;
        rd_addr_d    = rd_addr_q;
        rd_scr_d     = rd_scr_q;
        crc_err_d    = crc_err_q;
        resp         = RespNone;
        status       = '0;
        body         = '0;

        unique case (state_q)
            StRxIdle: begin
                // The start bit is 0, so with a zero seed it leaves the CRC unchanged.
                if (!sd_io.cmd_in) begin
                    state_d = StRx;
                    cnt_d   = '0;
                    crc_d   = '0;
                end
            end
            StRx: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd0) begin
                    if (!sd_io.cmd_in) state_d = StRxIdle;
                    crc_d = crc7_step(crc_q, sd_io.cmd_in);
                end else begin
                    rx_sr_d = {rx_sr_q[44:0], sd_io.cmd_in};
                    if (cnt_q <= 6'd38) crc_d = crc7_step(crc_q, sd_io.cmd_in);
                    if (cnt_q == 6'd46) state_d = StCheck;
                end
            end
            StCheck: begin
                state_d = StRxIdle;
                if ((crc_q != rx_crc) || !rx_end) begin
                    err_crc_d = 1'b1;
                    crc_err_d = 1'b1;
                end else begin
                    valid_d   = 1'b1;
                    index_d   = rx_idx;
                    arg_d     = rx_arg;
                    crc_err_d = 1'b0;
                    app_d     = (rx_idx == 6'd55);
                    if (rx_idx == 6'd0) begin
                        card_state_d = CardIdle;
                    end else if (rx_idx == 6'd55) begin
                        resp = RespR1;
                    end else if (app_q && rx_idx == 6'd41) begin
                        resp         = RespR3;
                        card_state_d = CardReady;
                    end else if (rx_idx == 6'd3) begin
                        resp         = RespR6;
                        card_state_d = CardStby;
                    end else if (rx_idx == 6'd7) begin
                        resp         = RespR1;
                        card_state_d = (rx_arg[31:16] == RCA) ? CardTran : CardStby;
                    end else if (rx_idx == 6'd17) begin
                        resp = RespR1;
                        if (card_state_q == CardTran) begin
                            rd_pend_d = 1'b1;
                            rd_addr_d = rx_arg;
                            rd_scr_d  = 1'b0;
                        end
                    end else if (app_q && rx_idx == 6'd51) begin
                        resp = RespR1;
                        if (card_state_q == CardTran) begin
                            rd_pend_d = 1'b1;
                            rd_addr_d = '0;
                            rd_scr_d  = 1'b1;
                        end
                    end else begin
                        err_ill_d = 1'b1;
                    end
                    status = {8'h00, err_crc_q, err_ill_q, 9'h000, card_state_q, 3'b000,
                              app_d, 5'h00};
                    case (resp)
                        RespR1: begin
                            body      = {2'b00, rx_idx, status};
                            tx_sr_d   = {body, crc7_of(body), 1'b1};
                            err_crc_d = 1'b0;
                            err_ill_d = 1'b0;
                        end
                        RespR6: begin
                            body    = {2'b00, 6'd3, RCA, 16'h0500};
                            tx_sr_d = {body, crc7_of(body), 1'b1};
                        end
                        RespR3:  tx_sr_d = {2'b00, 6'h3F, OCR, 7'h7F, 1'b1};
                        default: ;
                    endcase
                    if (resp != RespNone) begin
                        state_d = StWait;
                        cnt_d   = '0;
                    end
                end
            end
            StWait: begin
                if (cnt_q == WaitLast) begin
                    state_d = StTx;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            StTx: begin
                tx_sr_d   = {tx_sr_q[46:0], 1'b1};
                cnt_d     = cnt_q + 6'd1;
                rd_pend_d = 1'b0;
                if (cnt_q == 6'd47) state_d = StRxIdle;
            end
            default: state_d = StRxIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StRxIdle;
            card_state_q <= CardIdle;
            app_q        <= 1'b0;
            err_crc_q    <= 1'b0;
            err_ill_q    <= 1'b0;
            cnt_q        <= '0;
            crc_q        <= '0;
            rx_sr_q      <= '0;
            tx_sr_q      <= '1;
            rd_pend_q    <= 1'b0;
            valid_q      <= 1'b0;
            index_q      <= '0;
            arg_q        <= '0;
            rd_addr_q    <= '0;
            rd_scr_q     <= 1'b0;
            crc_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            card_state_q <= card_state_d;
            app_q        <= app_d;
            err_crc_q    <= err_crc_d;
            err_ill_q    <= err_ill_d;
            cnt_q        <= cnt_d;
            crc_q        <= crc_d;
            rx_sr_q      <= rx_sr_d;
            tx_sr_q      <= tx_sr_d;
            rd_pend_q    <= rd_pend_d;
            valid_q      <= valid_d;
            index_q      <= index_d;
            arg_q        <= arg_d;
            rd_addr_q    <= rd_addr_d;
            rd_scr_q     <= rd_scr_d;
            crc_err_q    <= crc_err_d;
        end
    end

    assign sd_io.cmd_oe    = (state_q == StTx);
    assign sd_io.cmd_out   = (state_q == StTx) ? tx_sr_q[47] : 1'b1;
    assign sd_io.rd_start  = (state_q == StTx) && (cnt_q == 6'd0) && rd_pend_q;
    assign sd_io.cmd_valid = valid_q;
    assign sd_io.cmd_index = index_q;
    assign sd_io.cmd_arg   = arg_q;
    assign sd_io.rd_addr   = rd_addr_q;
    assign sd_io.rd_scr    = rd_scr_q;
    assign sd_io.crc_err   = crc_err_q;

endmodule
